// File: rtl/clock_pkg.sv
// Shared mode/field encodings for the digital clock controller.
// Also holds the field-advance and field-to-group helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET       = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_ALARM     = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        FLD_NONE = 3'd0,
        FLD_SEC  = 3'd1,
        FLD_MIN  = 3'd2,
        FLD_HOUR = 3'd3,
        FLD_DAY  = 3'd4,
        FLD_MON  = 3'd5,
        FLD_YEAR = 3'd6
    } field_e;

    localparam int GRP_LO  = 0;
    localparam int GRP_MID = 1;
    localparam int GRP_HI  = 2;

    function automatic field_e set_next(field_e f);
        field_e n;
        case (f)
            FLD_SEC:  n = FLD_MIN;
            FLD_MIN:  n = FLD_HOUR;
            FLD_HOUR: n = FLD_DAY;
            FLD_DAY:  n = FLD_MON;
            FLD_MON:  n = FLD_YEAR;
            default:  n = FLD_SEC;
        endcase
        return n;
    endfunction

    function automatic field_e alarm_next(field_e f);
        field_e n;
        case (f)
            FLD_SEC: n = FLD_MIN;
            FLD_MIN: n = FLD_HOUR;
            default: n = FLD_SEC;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] field_grp(field_e f);
        logic [2:0] m;
        m = '0;
        case (f)
            FLD_SEC, FLD_DAY:  m[GRP_LO]  = 1'b1;
            FLD_MIN, FLD_MON:  m[GRP_MID] = 1'b1;
            FLD_HOUR, FLD_YEAR: m[GRP_HI] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_controller_if.sv
// Time sources in, mode/command/display signals out.
// master = clock top level side, slave = mode_controller.
interface mode_controller_if;
    logic [5:0] clk_sec;
    logic [5:0] clk_min;
    logic [5:0] clk_hour;
    logic [4:0] clk_day;
    logic [4:0] clk_mon;
    logic [6:0] clk_year_lo;
    logic [5:0] sw_sec;
    logic [5:0] sw_min;
    logic [5:0] sw_hour;
    logic [5:0] al_sec;
    logic [5:0] al_min;
    logic [5:0] al_hour;
    logic [1:0] mode;
    logic [2:0] field_sel;
    logic       set_inc;
    logic       alarm_inc;
    logic       sw_run;
    logic       sw_clear;
    logic [6:0] disp_hi;
    logic [6:0] disp_mid;
    logic [6:0] disp_lo;
    logic [2:0] blank_mask;

    modport master (
        output clk_sec, clk_min, clk_hour,
        output clk_day, clk_mon, clk_year_lo,
        output sw_sec, sw_min, sw_hour,
        output al_sec, al_min, al_hour,
        input  mode, field_sel,
        input  set_inc, alarm_inc, sw_run, sw_clear,
        input  disp_hi, disp_mid, disp_lo, blank_mask
    );

    modport slave (
        input  clk_sec, clk_min, clk_hour,
        input  clk_day, clk_mon, clk_year_lo,
        input  sw_sec, sw_min, sw_hour,
        input  al_sec, al_min, al_hour,
        output mode, field_sel,
        output set_inc, alarm_inc, sw_run, sw_clear,
        output disp_hi, disp_mid, disp_lo, blank_mask
    );
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> stability counter -> rising-edge pulse.
// Press pulse is high for the single cycle after level acceptance + 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_50,
    input  logic rst,
    input  logic raw,
    output logic press_pulse
);
    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
            // Any sample agreeing with the accepted level restarts the wait
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_pulse = pulse_q;
endmodule

// File: rtl/mode_controller.sv
// Button/mode sequencer: debounced presses drive the mode FSM,
// command pulses, display source mux and edit-field blink mask.
module mode_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic clk_50,
    input  logic rst,
    input  logic mode_btn,
    input  logic st_btn,
    input  logic up_btn,
    mode_controller_if.slave bus
);
    localparam int BW =
        (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic mode_p;
    logic st_p;
    logic up_p;

    mode_e         mode_q;
    field_e        field_q;
    logic          set_inc_q;
    logic          alarm_inc_q;
    logic          sw_run_q;
    logic          sw_clear_q;
    logic [6:0]    hi_q;
    logic [6:0]    mid_q;
    logic [6:0]    lo_q;
    logic [2:0]    blank_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk_50(clk_50), .rst(rst), .raw(mode_btn), .press_pulse(mode_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_st_db (
        .clk_50(clk_50), .rst(rst), .raw(st_btn), .press_pulse(st_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk_50(clk_50), .rst(rst), .raw(up_btn), .press_pulse(up_p)
    );

    // mode beats select beats up; losers in the same cycle are dropped
    always_ff @(posedge clk_50) begin
        if (rst) begin
            mode_q      <= MODE_CLOCK;
            field_q     <= FLD_NONE;
            set_inc_q   <= 1'b0;
            alarm_inc_q <= 1'b0;
            sw_run_q    <= 1'b0;
            sw_clear_q  <= 1'b0;
        end else begin
            set_inc_q   <= 1'b0;
            alarm_inc_q <= 1'b0;
            sw_clear_q  <= 1'b0;
            if (mode_p) begin
                unique case (mode_q)
                    MODE_CLOCK: begin
                        mode_q  <= MODE_SET;
                        field_q <= FLD_SEC;
                    end
                    MODE_SET: begin
                        mode_q  <= MODE_STOPWATCH;
                        field_q <= FLD_NONE;
                    end
                    MODE_STOPWATCH: begin
                        mode_q  <= MODE_ALARM;
                        field_q <= FLD_SEC;
                    end
                    MODE_ALARM: begin
                        mode_q  <= MODE_CLOCK;
                        field_q <= FLD_NONE;
                    end
                endcase
            end else if (st_p) begin
                case (mode_q)
                    MODE_SET:       field_q  <= set_next(field_q);
                    MODE_ALARM:     field_q  <= alarm_next(field_q);
                    MODE_STOPWATCH: sw_run_q <= ~sw_run_q;
                    default: ;
                endcase
            end else if (up_p) begin
                case (mode_q)
                    MODE_SET:       set_inc_q   <= 1'b1;
                    MODE_ALARM:     alarm_inc_q <= 1'b1;
                    MODE_STOPWATCH: sw_clear_q  <= ~sw_run_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            hi_q    <= '0;
            mid_q   <= '0;
            lo_q    <= '0;
            blank_q <= '0;
        end else begin
            case (mode_q)
                MODE_STOPWATCH: begin
                    hi_q  <= {1'b0, bus.sw_hour};
                    mid_q <= {1'b0, bus.sw_min};
                    lo_q  <= {1'b0, bus.sw_sec};
                end
                MODE_ALARM: begin
                    hi_q  <= {1'b0, bus.al_hour};
                    mid_q <= {1'b0, bus.al_min};
                    lo_q  <= {1'b0, bus.al_sec};
                end
                default: begin
                    if (mode_q == MODE_SET && field_q inside
                        {FLD_DAY, FLD_MON, FLD_YEAR}) begin
                        hi_q  <= bus.clk_year_lo;
                        mid_q <= {2'b00, bus.clk_mon};
                        lo_q  <= {2'b00, bus.clk_day};
                    end else begin
                        hi_q  <= {1'b0, bus.clk_hour};
                        mid_q <= {1'b0, bus.clk_min};
                        lo_q  <= {1'b0, bus.clk_sec};
                    end
                end
            endcase
            if ((mode_q == MODE_SET || mode_q == MODE_ALARM)
                && !blink_phase_q) begin
                blank_q <= field_grp(field_q);
            end else begin
                blank_q <= '0;
            end
        end
    end

    assign bus.mode       = mode_q;
    assign bus.field_sel  = field_q;
    assign bus.set_inc    = set_inc_q;
    assign bus.alarm_inc  = alarm_inc_q;
    assign bus.sw_run     = sw_run_q;
    assign bus.sw_clear   = sw_clear_q;
    assign bus.disp_hi    = hi_q;
    assign bus.disp_mid   = mid_q;
    assign bus.disp_lo    = lo_q;
    assign bus.blank_mask = blank_q;
endmodule

// File: tb/tb_mode_controller.sv
// Bench for mode_controller: vector table, corner sequences and
// random button presses against a press-level reference model.
module tb_mode_controller;
    localparam int DB = 4;
    localparam int BL = 8;

    typedef struct {
        logic [2:0] btn;
        int mode;
        int field;
        int run;
        int n_set;
        int n_al;
        int n_clr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_btn = 1'b0;
    logic st_btn = 1'b0;
    logic up_btn = 1'b0;

    mode_controller_if bus();

    mode_controller #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_CYCLES(BL)
    ) dut (
        .clk_50(clk),
        .rst(rst),
        .mode_btn(mode_btn),
        .st_btn(st_btn),
        .up_btn(up_btn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_set = 0;
    int n_al = 0;
    int n_clr = 0;

    int m_mode = 0;
    int m_field = 0;
    int m_run = 0;

    vec_t tbl[26];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_set <= n_set + int'(bus.set_inc);
            n_al  <= n_al + int'(bus.alarm_inc);
            n_clr <= n_clr + int'(bus.sw_clear);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Spec-level effect of one debounced press (b = {mode,st,up})
    task automatic model_apply(input logic [2:0] b, output int ds,
                               output int da, output int dc);
        ds = 0; da = 0; dc = 0;
        if (b[2]) begin
            m_mode = (m_mode + 1) % 4;
            m_field = (m_mode == 1 || m_mode == 3) ? 1 : 0;
        end else if (b[1]) begin
            if (m_mode == 1) m_field = m_field % 6 + 1;
            else if (m_mode == 3) m_field = m_field % 3 + 1;
            else if (m_mode == 2) m_run = 1 - m_run;
        end else if (b[0]) begin
            if (m_mode == 1) ds = 1;
            else if (m_mode == 3) da = 1;
            else if (m_mode == 2 && m_run == 0) dc = 1;
        end
    endtask

    function automatic int grp_of(int f);
        case (f)
            1, 4: return 1;
            2, 5: return 2;
            3, 6: return 4;
            default: return 0;
        endcase
    endfunction

    // k = edges since the reset edge; mask reflects phase before edge k
    function automatic int exp_blank(int k);
        int ph;
        if (k < 1) return 0;
        ph = 1 ^ (((k - 1) / BL) & 1);
        if ((m_mode == 1 || m_mode == 3) && ph == 0)
            return grp_of(m_field);
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {mode_btn, st_btn, up_btn} = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_field = 0; m_run = 0;
    endtask

    task automatic press(input logic [2:0] b, output int ds,
                         output int da, output int dc);
        int s0, a0, c0;
        @(negedge clk);
        s0 = n_set; a0 = n_al; c0 = n_clr;
        {mode_btn, st_btn, up_btn} = b;
        repeat (10) @(negedge clk);
        {mode_btn, st_btn, up_btn} = 3'b000;
        repeat (10) @(negedge clk);
        ds = n_set - s0; da = n_al - a0; dc = n_clr - c0;
    endtask

    task automatic press_model(input logic [2:0] b, input string tag);
        int ds, da, dc, es, ea, ec;
        press(b, ds, da, dc);
        model_apply(b, es, ea, ec);
        chk({tag, ".mode"}, int'(bus.mode), m_mode);
        chk({tag, ".field"}, int'(bus.field_sel), m_field);
        chk({tag, ".sw_run"}, int'(bus.sw_run), m_run);
        chk({tag, ".set_inc"}, ds, es);
        chk({tag, ".alarm_inc"}, da, ea);
        chk({tag, ".sw_clear"}, dc, ec);
    endtask

    task automatic chk_disp(input string tag);
        int eh, em, el;
        if (m_mode == 2) begin
            eh = int'(bus.sw_hour); em = int'(bus.sw_min);
            el = int'(bus.sw_sec);
        end else if (m_mode == 3) begin
            eh = int'(bus.al_hour); em = int'(bus.al_min);
            el = int'(bus.al_sec);
        end else if (m_mode == 1 && m_field >= 4) begin
            eh = int'(bus.clk_year_lo); em = int'(bus.clk_mon);
            el = int'(bus.clk_day);
        end else begin
            eh = int'(bus.clk_hour); em = int'(bus.clk_min);
            el = int'(bus.clk_sec);
        end
        chk({tag, ".disp_hi"}, int'(bus.disp_hi), eh);
        chk({tag, ".disp_mid"}, int'(bus.disp_mid), em);
        chk({tag, ".disp_lo"}, int'(bus.disp_lo), el);
        chk({tag, ".blank"}, int'(bus.blank_mask), exp_blank(cyc));
    endtask

    task automatic rand_data();
        bus.clk_sec = 6'($urandom_range(0, 59));
        bus.clk_min = 6'($urandom_range(0, 59));
        bus.clk_hour = 6'($urandom_range(0, 23));
        bus.clk_day = 5'($urandom_range(1, 31));
        bus.clk_mon = 5'($urandom_range(1, 12));
        bus.clk_year_lo = 7'($urandom_range(0, 99));
        bus.sw_sec = 6'($urandom_range(0, 63));
        bus.sw_min = 6'($urandom_range(0, 63));
        bus.sw_hour = 6'($urandom_range(0, 63));
        bus.al_sec = 6'($urandom_range(0, 59));
        bus.al_min = 6'($urandom_range(0, 59));
        bus.al_hour = 6'($urandom_range(0, 23));
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, ".mode"}, int'(bus.mode), 0);
        chk({tag, ".field"}, int'(bus.field_sel), 0);
        chk({tag, ".sw_run"}, int'(bus.sw_run), 0);
        chk({tag, ".pulses"},
            int'({bus.set_inc, bus.alarm_inc, bus.sw_clear}), 0);
        chk({tag, ".disp"},
            int'({bus.disp_hi, bus.disp_mid, bus.disp_lo}), 0);
        chk({tag, ".blank"}, int'(bus.blank_mask), 0);
    endtask

    initial begin
        int ds, da, dc;
        logic [2:0] b;

        tbl[0]  = '{3'b100, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{3'b010, 1, 2, 0, 0, 0, 0};
        tbl[2]  = '{3'b010, 1, 3, 0, 0, 0, 0};
        tbl[3]  = '{3'b010, 1, 4, 0, 0, 0, 0};
        tbl[4]  = '{3'b010, 1, 5, 0, 0, 0, 0};
        tbl[5]  = '{3'b010, 1, 6, 0, 0, 0, 0};
        tbl[6]  = '{3'b010, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{3'b001, 1, 1, 0, 1, 0, 0};
        tbl[8]  = '{3'b100, 2, 0, 0, 0, 0, 0};
        tbl[9]  = '{3'b010, 2, 0, 1, 0, 0, 0};
        tbl[10] = '{3'b001, 2, 0, 1, 0, 0, 0};
        tbl[11] = '{3'b010, 2, 0, 0, 0, 0, 0};
        tbl[12] = '{3'b001, 2, 0, 0, 0, 0, 1};
        tbl[13] = '{3'b010, 2, 0, 1, 0, 0, 0};
        tbl[14] = '{3'b100, 3, 1, 1, 0, 0, 0};
        tbl[15] = '{3'b010, 3, 2, 1, 0, 0, 0};
        tbl[16] = '{3'b010, 3, 3, 1, 0, 0, 0};
        tbl[17] = '{3'b010, 3, 1, 1, 0, 0, 0};
        tbl[18] = '{3'b001, 3, 1, 1, 0, 1, 0};
        tbl[19] = '{3'b100, 0, 0, 1, 0, 0, 0};
        tbl[20] = '{3'b010, 0, 0, 1, 0, 0, 0};
        tbl[21] = '{3'b001, 0, 0, 1, 0, 0, 0};
        tbl[22] = '{3'b100, 1, 1, 1, 0, 0, 0};
        tbl[23] = '{3'b110, 2, 0, 1, 0, 0, 0};
        tbl[24] = '{3'b011, 2, 0, 0, 0, 0, 0};
        tbl[25] = '{3'b001, 2, 0, 0, 0, 0, 1};

        rand_data();
        do_reset();
        chk_all_reset("reset");

        // exact press latency: mode changes after edge N+DB+3
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (DB + 3) @(negedge clk);
        chk("latency.before", int'(bus.mode), 0);
        @(negedge clk);
        chk("latency.mode", int'(bus.mode), 1);
        chk("latency.field", int'(bus.field_sel), 1);
        mode_btn = 1'b0;
        repeat (12) @(negedge clk);
        model_apply(3'b100, ds, da, dc);

        // glitch one cycle shorter than the debounce window
        mode_btn = 1'b1;
        repeat (DB - 1) @(negedge clk);
        mode_btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch.mode", int'(bus.mode), 1);
        chk("glitch.field", int'(bus.field_sel), 1);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            press(tbl[i].btn, ds, da, dc);
            chk($sformatf("vec%0d.mode", i), int'(bus.mode), tbl[i].mode);
            chk($sformatf("vec%0d.field", i), int'(bus.field_sel),
                tbl[i].field);
            chk($sformatf("vec%0d.sw_run", i), int'(bus.sw_run),
                tbl[i].run);
            chk($sformatf("vec%0d.set_inc", i), ds, tbl[i].n_set);
            chk($sformatf("vec%0d.alarm_inc", i), da, tbl[i].n_al);
            chk($sformatf("vec%0d.sw_clear", i), dc, tbl[i].n_clr);
        end

        // date fields on the display
        do_reset();
        press_model(3'b100, "date");
        for (int i = 0; i < 3; i++) press_model(3'b010, "date");
        bus.clk_year_lo = 7'd24;
        bus.clk_mon = 5'd5;
        bus.clk_day = 5'd17;
        repeat (2) @(negedge clk);
        chk("date.field", int'(bus.field_sel), 4);
        chk("date.hi", int'(bus.disp_hi), 24);
        chk("date.mid", int'(bus.disp_mid), 5);
        chk("date.lo", int'(bus.disp_lo), 17);

        // blink on MIN in SET, then none in CLOCK
        do_reset();
        press_model(3'b100, "blink");
        press_model(3'b010, "blink");
        for (int i = 0; i < 4 * BL; i++) begin
            @(negedge clk);
            chk("blink.set", int'(bus.blank_mask), exp_blank(cyc));
        end
        for (int i = 0; i < 3; i++) press_model(3'b100, "blink");
        for (int i = 0; i < 2 * BL; i++) begin
            @(negedge clk);
            chk("blink.clock", int'(bus.blank_mask), 0);
        end

        // reset mid-debounce, stopwatch running, sitting in SET
        do_reset();
        press_model(3'b100, "rstmid");
        press_model(3'b100, "rstmid");
        press_model(3'b010, "rstmid");
        for (int i = 0; i < 3; i++) press_model(3'b100, "rstmid");
        rand_data();
        mode_btn = 1'b1;
        repeat (DB) @(negedge clk);
        rst = 1'b1;
        mode_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0; m_field = 0; m_run = 0;
        chk_all_reset("rstmid");
        repeat (15) @(negedge clk);
        chk("rstmid.quiet", int'(bus.mode), 0);

        // random presses against the reference model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: b = 3'b100;
                3, 4, 5: b = 3'b010;
                6, 7:    b = 3'b001;
                default: b = 3'($urandom_range(1, 7));
            endcase
            press_model(b, $sformatf("rnd%0d", i));
            rand_data();
            repeat (2) @(negedge clk);
            chk_disp($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
Central button and mode sequencer for the digital clock top level. It debounces and edge-detects the three raw buttons and runs the mode FSM (CLOCK, SET, STOPWATCH, ALARM). It steers one-cycle command pulses to the clock modifier, up-counter and alarm blocks. It also muxes the active data source onto the three two-digit FND groups, with blink masking of the field being edited.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz)
BLINK_CYCLES, 12_500_000, half-period of the edit-field blink, in clk_50 cycles

Ports:
clk_50  in  1  system clock, 50 MHz
rst  in  1  reset (one clock; reset is synchronous and active-high)
mode_btn  in  1  raw mode button, active-high, asynchronous to clk_50
st_btn  in  1  raw select/start button, active-high, asynchronous
up_btn  in  1  raw increment/clear button, active-high, asynchronous
clk_sec, clk_min, clk_hour  in  6 each  running clock time
clk_day, clk_mon  in  5 each  running date
clk_year_lo  in  7  year mod 100
sw_sec, sw_min, sw_hour  in  6 each  up-counter value
al_sec, al_min, al_hour  in  6 each  alarm setting
mode  out  2  0=CLOCK, 1=SET, 2=STOPWATCH, 3=ALARM
field_sel  out  3  0=NONE, 1=SEC, 2=MIN, 3=HOUR, 4=DAY, 5=MON, 6=YEAR
set_inc  out  1  one-cycle increment pulse to clock_Modifier
alarm_inc  out  1  one-cycle increment pulse to alarm block
sw_run  out  1  up-counter run enable (level)
sw_clear  out  1  one-cycle up-counter clear pulse
disp_hi, disp_mid, disp_lo  out  7 each  values for FND groups 5-6, 3-4, 1-2
blank_mask  out  3  bit2=hi, bit1=mid, bit0=lo; 1 = blank that group

Behaviour:
- Reset values: mode=0, field_sel=0, all pulses 0, sw_run=0, disp_*=0, blank_mask=0, blink counter 0, blink_phase=1. Synchronizers, accepted levels and debounce counters are all cleared.
- Button path, per button:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter increments each cycle the sync output differs from the accepted level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A registered rising-edge detect on the accepted level produces the press pulse.
  - A stable press first sampled at edge N gives a pulse high for exactly the one cycle after edge N+DEBOUNCE_CYCLES+2. Releases produce no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Priority within one cycle: mode_pulse > st_pulse > up_pulse. A lower-priority pulse in the same cycle is dropped.
- Mode FSM, on mode_pulse: CLOCK->SET->STOPWATCH->ALARM->CLOCK (wrap 3->0).
  - Entering SET or ALARM sets field_sel=SEC.
  - Entering CLOCK or STOPWATCH sets field_sel=NONE.
- SET: st_pulse cycles field_sel SEC->MIN->HOUR->DAY->MON->YEAR->SEC. up_pulse gives set_inc=1 for 1 cycle.
- ALARM: st_pulse cycles SEC->MIN->HOUR->SEC. up_pulse gives alarm_inc=1 for 1 cycle.
- STOPWATCH:
  - st_pulse toggles sw_run.
  - up_pulse with sw_run=0 gives sw_clear=1 for 1 cycle. up_pulse with sw_run=1 is ignored.
  - Leaving STOPWATCH does not change sw_run; the stopwatch keeps running in the background.
- CLOCK: st_pulse and up_pulse are ignored.
- Pulse outputs are registered and assert the cycle after the press pulse.
- Display mux, registered with 1-cycle latency:
  - CLOCK, and SET with field SEC/MIN/HOUR: hi/mid/lo = clk_hour/clk_min/clk_sec.
  - SET with field DAY/MON/YEAR: hi/mid/lo = clk_year_lo/clk_mon/clk_day.
  - STOPWATCH: sw_hour/sw_min/sw_sec.
  - ALARM: al_hour/al_min/al_sec.
  - All 6- and 5-bit inputs are zero-extended to 7 bits.
- Blink:
  - The counter wraps at BLINK_CYCLES-1 and toggles blink_phase. It runs freely.
  - In SET/ALARM with blink_phase=0, the bit of the edited group is set in blank_mask. SEC/DAY map to lo, MIN/MON to mid, HOUR/YEAR to hi. All other bits are 0.
  - In CLOCK/STOPWATCH, blank_mask=0.
- Synchronous rst in mid-operation (mid-debounce, sw_run=1, in SET) returns everything to its reset values on the next edge.

Decomposition:
- Shared package clock_pkg holds:
  - mode encodings MODE_CLOCK..MODE_ALARM
  - field encodings FLD_NONE..FLD_YEAR
  - group-bit constants GRP_LO/GRP_MID/GRP_HI
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk_50, rst, raw, press_pulse), instantiated three times.

Test Plan:
1. DEBOUNCE_CYCLES=4; hold mode_btn high from edge 10 -> one pulse; mode becomes 1 and field_sel=1 exactly after edge 17. A 3-cycle glitch -> no change.
2. From SET: 6 st_btn presses -> field_sel 2,3,4,5,6,1. At field 4, disp_hi/mid/lo = clk_year_lo/clk_mon/clk_day (e.g. 24/5/17). up press -> set_inc high for exactly 1 cycle.
3. STOPWATCH: st -> sw_run=1; up -> no sw_clear; st -> sw_run=0; up -> sw_clear 1 cycle. Mode press -> ALARM with sw_run unchanged.
4. Four mode presses from CLOCK -> mode wraps 3->0 with field_sel=0. In ALARM, 3 st presses -> 2,3,1. up -> alarm_inc only; set_inc stays 0.
5. BLINK_CYCLES=8, SET, field MIN -> blank_mask toggles 3'b000/3'b010 every 8 cycles. In CLOCK -> blank_mask=0.
6. Force mode_pulse and st_pulse in the same cycle in SET -> mode=2, field_sel=0, no field advance. Assert rst while sw_run=1 -> all outputs at reset values next cycle.
